seq_param_const_gen: RTL

Parametrised sequence source. After reset it drives a compile-time constant. On `start` it emits a burst of `count` values over a val/rdy output, stepping the value each accepted transfer according to a runtime-selected mode (hold, increment, decrement, rotate). It serves as a configurable stimulus/constant generator feeding val/rdy consumers, and generalises a fixed parametrised constant into a stateful, flow-controlled sequence.

---
 rtl/seq_param_const_gen.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/seq_param_const_gen.sv
// -----------------------------------------------------------------------------
// seq_param_const_gen
//
// Parametrised sequence source. Out of reset it presents a compile-time
// constant on `out`. A `start` in IDLE launches a burst of `count` values
// over a val/rdy interface. The data register steps on every accepted
// transfer according to the mode latched with `start`:
//   0 HOLD, 1 INC (+stride), 2 DEC (-stride), 3 ROTL (rotate left by one).
// A one-cycle `done` pulse follows the last transfer, and then the block
// returns to IDLE. The data register carries over between bursts.
//
// Parameters:
//   nbits  - data width (>= 1)
//   value  - reset/initial data value
//   stride - INC/DEC step, truncated to nbits
//   count  - values per burst (>= 1)
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-high reset
//   start    in   begin a burst (sampled in IDLE only)
//   mode     in   step mode, sampled together with start
//   ld_en    in   load data register from ld_data (IDLE only)
//   ld_data  in   value to load
//   out_val  out  output valid (RUN state)
//   out_rdy  in   consumer ready
//   out      out  current data register, always driven
//   done     out  one-cycle burst-complete pulse
// -----------------------------------------------------------------------------
module seq_param_const_gen #(
    parameter int unsigned      nbits  = 8,
    parameter logic [nbits-1:0] value  = '0,
    parameter int unsigned      stride = 1,
    parameter int unsigned      count  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic             ld_en,
    input  logic [nbits-1:0] ld_data,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [nbits-1:0] out,
    output logic             done
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int unsigned      REM_W   = $clog2(count + 1);
    localparam logic [REM_W-1:0] COUNT_T = REM_W'(count);
    localparam logic [REM_W-1:0] REM_ONE = REM_W'(1);
    localparam logic [nbits-1:0] STEP    = nbits'(stride);

    localparam logic [1:0] MODE_HOLD = 2'd0;
    localparam logic [1:0] MODE_INC  = 2'd1;
    localparam logic [1:0] MODE_DEC  = 2'd2;
    localparam logic [1:0] MODE_ROTL = 2'd3;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]       state;
    logic [nbits-1:0] dreg;
    logic [1:0]       mode_q;
    logic [REM_W-1:0] remaining;

    logic             hs;
    logic [nbits-1:0] rot;
    logic [nbits-1:0] stepped;

    // ------------------------------------------------------------------
    // Next-value datapath
    // ------------------------------------------------------------------
    // A one-bit rotate is the identity. It gets its own branch so that the
    // dreg[nbits-2:0] slice is never elaborated when nbits is 1.
    generate
        if (nbits == 1) begin : g_rot_w1
            assign rot = dreg;
        end else begin : g_rot_wn
            assign rot = {dreg[nbits-2:0], dreg[nbits-1]};
        end
    endgenerate

    always_comb begin
        stepped = dreg;
        case (mode_q)
            MODE_HOLD: stepped = dreg;
            MODE_INC:  stepped = dreg + STEP;
            MODE_DEC:  stepped = dreg - STEP;
            MODE_ROTL: stepped = rot;
            default:   stepped = dreg;
        endcase
    end

    // A transfer happens only in RUN. out_val is a pure state decode, so
    // this also covers the IDLE and DONE cycles.
    assign hs = out_val & out_rdy;

    // ------------------------------------------------------------------
    // FSM and registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            dreg      <= value;
            mode_q    <= MODE_HOLD;
            remaining <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // Load and start may coincide. The load wins the data
                    // register, so the first burst value is ld_data.
                    if (ld_en) begin
                        dreg <= ld_data;
                    end
                    if (start) begin
                        mode_q    <= mode;
                        remaining <= COUNT_T;
                        state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (hs) begin
                        dreg      <= stepped;
                        remaining <= remaining - REM_ONE;
                        if (remaining == REM_ONE) begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from registered state only
    // ------------------------------------------------------------------
    assign out_val = (state == S_RUN);
    assign done    = (state == S_DONE);
    assign out     = dreg;

endmodule
